// File: rtl/j17_pkg.sv
// Shared constants for the multi-cycle control unit: opcodes, FSM state codes and ALU select codes.
package j17_pkg;

  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_MUL  = 2;
  localparam int OP_ADDI = 3;
  localparam int OP_LW   = 4;
  localparam int OP_SW   = 5;
  localparam int OP_BEQ  = 6;
  localparam int OP_JMP  = 7;
  localparam int OP_HALT = 63;

  typedef logic [2:0] state_t;

  localparam state_t S_FETCH  = 3'd0;
  localparam state_t S_DECODE = 3'd1;
  localparam state_t S_EXEC   = 3'd2;
  localparam state_t S_MEM    = 3'd3;
  localparam state_t S_WB     = 3'd4;
  localparam state_t S_HALT   = 3'd5;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_MUL = 2'd2;

endpackage

// File: rtl/cu_decode.sv
// Combinational opcode classifier; also picks the ALU operation each class needs.
module cu_decode
  import j17_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic [OPW-1:0] opcode,
  output logic           is_alu,
  output logic           is_imm,
  output logic           is_load,
  output logic           is_store,
  output logic           is_branch,
  output logic           is_jump,
  output logic           is_halt,
  output logic           is_illegal,
  output logic [1:0]     alu_sel
);

  logic op_add;
  logic op_sub;
  logic op_mul;

  assign op_add    = (opcode == OPW'(OP_ADD));
  assign op_sub    = (opcode == OPW'(OP_SUB));
  assign op_mul    = (opcode == OPW'(OP_MUL));
  assign is_alu    = op_add | op_sub | op_mul;
  assign is_imm    = (opcode == OPW'(OP_ADDI));
  assign is_load   = (opcode == OPW'(OP_LW));
  assign is_store  = (opcode == OPW'(OP_SW));
  assign is_branch = (opcode == OPW'(OP_BEQ));
  assign is_jump   = (opcode == OPW'(OP_JMP));
  assign is_halt   = (opcode == OPW'(OP_HALT));

  assign is_illegal = !(is_alu | is_imm | is_load | is_store |
                        is_branch | is_jump | is_halt);

  // BEQ compares by subtraction; everything else that is not SUB/MUL adds.
  always_comb begin
    alu_sel = ALU_ADD;
    if (op_sub || is_branch) alu_sel = ALU_SUB;
    else if (op_mul)         alu_sel = ALU_MUL;
  end

endmodule

// File: rtl/control_unit_mc.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with sticky HALT and a
// retired-instruction counter. The current FSM state is exported on the state port.
module control_unit_mc
  import j17_pkg::*;
#(
  parameter int IW  = 32,
  parameter int OPW = 6,
  parameter int RW  = 5,
  parameter int CW  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [IW-1:0]         instruction,
  input  logic                  mem_ready,
  input  logic                  zero,
  output logic [OPW-1:0]        opcode,
  output logic [RW-1:0]         op1,
  output logic [RW-1:0]         op2,
  output logic [IW-OPW-2*RW-1:0] imm,
  output logic                  imControl,
  output logic                  regenable,
  output logic                  ramenable,
  output logic                  ramread,
  output logic                  fetch,
  output logic                  pcControl,
  output logic                  pcenable,
  output logic [1:0]            aluop,
  output logic                  illegal,
  output logic                  halted,
  output logic [CW-1:0]         retired,
  output logic [2:0]            state
);

  state_t        state_q;
  state_t        state_d;
  logic [IW-1:0] ir;
  logic          ir_load;
  logic          retire;

  logic          is_alu;
  logic          is_imm;
  logic          is_load;
  logic          is_store;
  logic          is_branch;
  logic          is_jump;
  logic          is_halt;
  logic          is_illegal;
  logic [1:0]    alu_sel;

  assign opcode = ir[IW-1 -: OPW];
  assign op1    = ir[IW-OPW-1 -: RW];
  assign op2    = ir[IW-OPW-RW-1 -: RW];
  assign imm    = ir[IW-OPW-2*RW-1:0];
  assign state  = state_q;

  cu_decode #(.OPW(OPW)) u_decode (
    .opcode     (opcode),
    .is_alu     (is_alu),
    .is_imm     (is_imm),
    .is_load    (is_load),
    .is_store   (is_store),
    .is_branch  (is_branch),
    .is_jump    (is_jump),
    .is_halt    (is_halt),
    .is_illegal (is_illegal),
    .alu_sel    (alu_sel)
  );

  // Memory handshake: a request (fetch, ramread or ramenable) is held steady until the
  // cycle in which mem_ready is sampled high; that cycle completes the transfer.
  always_comb begin
    state_d = state_q;
    ir_load = 1'b0;
    retire  = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          ir_load = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_halt)         state_d = S_HALT;
        else if (is_illegal) state_d = S_FETCH;
        else                 state_d = S_EXEC;
      end
      S_EXEC: begin
        if (is_load || is_store) begin
          state_d = S_MEM;
        end else if (is_branch || is_jump) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          if (is_load) begin
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      ir      <= '0;
      retired <= '0;
    end else begin
      state_q <= state_d;
      if (ir_load) ir <= instruction;
      if (retire)  retired <= retired + CW'(1);
    end
  end

  // Reset gates every strobe so an in-flight access is dropped the moment reset rises.
  always_comb begin
    fetch     = 1'b0;
    pcenable  = 1'b0;
    illegal   = 1'b0;
    aluop     = ALU_ADD;
    imControl = 1'b0;
    pcControl = 1'b0;
    ramread   = 1'b0;
    ramenable = 1'b0;
    regenable = 1'b0;
    halted    = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          fetch    = 1'b1;
          pcenable = mem_ready;
        end
        S_DECODE: illegal = is_illegal;
        S_EXEC: begin
          aluop     = alu_sel;
          imControl = is_imm | is_load | is_store;
          pcControl = is_jump | (is_branch & zero);
        end
        S_MEM: begin
          ramread   = is_load;
          ramenable = is_store;
        end
        S_WB:    regenable = 1'b1;
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit_mc.sv
// Directed bench for control_unit_mc: drivers push per-cycle expected outputs, a negedge monitor compares.
module tb_control_unit_mc;

  localparam int IW  = 32;
  localparam int OPW = 6;
  localparam int RW  = 5;
  localparam int CW  = 4;
  localparam int VW  = 18;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd5;

  // enable bit order: fetch, pcenable, regenable, ramread, ramenable, pcControl, imControl
  localparam logic [6:0] E_F  = 7'b1000000;
  localparam logic [6:0] E_PE = 7'b0100000;
  localparam logic [6:0] E_RE = 7'b0010000;
  localparam logic [6:0] E_RR = 7'b0001000;
  localparam logic [6:0] E_WE = 7'b0000100;
  localparam logic [6:0] E_PC = 7'b0000010;
  localparam logic [6:0] E_IM = 7'b0000001;

  logic                    clock = 1'b0;
  logic                    reset;
  logic [IW-1:0]           instruction;
  logic                    mem_ready;
  logic                    zero;
  logic [OPW-1:0]          opcode;
  logic [RW-1:0]           op1;
  logic [RW-1:0]           op2;
  logic [IW-OPW-2*RW-1:0]  imm;
  logic                    imControl;
  logic                    regenable;
  logic                    ramenable;
  logic                    ramread;
  logic                    fetch;
  logic                    pcControl;
  logic                    pcenable;
  logic [1:0]              aluop;
  logic                    illegal;
  logic                    halted;
  logic [CW-1:0]           retired;
  logic [2:0]              state;

  logic [VW-1:0] exp_q[$];
  string         tag_q[$];
  logic [VW-1:0] act;
  logic [VW-1:0] mon_v;
  string         mon_t;
  logic [CW-1:0] exp_ret;
  int            tests = 0;
  int            fails = 0;

  control_unit_mc #(.IW(IW), .OPW(OPW), .RW(RW), .CW(CW)) dut (
    .clock       (clock),
    .reset       (reset),
    .instruction (instruction),
    .mem_ready   (mem_ready),
    .zero        (zero),
    .opcode      (opcode),
    .op1         (op1),
    .op2         (op2),
    .imm         (imm),
    .imControl   (imControl),
    .regenable   (regenable),
    .ramenable   (ramenable),
    .ramread     (ramread),
    .fetch       (fetch),
    .pcControl   (pcControl),
    .pcenable    (pcenable),
    .aluop       (aluop),
    .illegal     (illegal),
    .halted      (halted),
    .retired     (retired),
    .state       (state)
  );

  // clock / reset
  always #5 clock = ~clock;

  assign act = {state, fetch, pcenable, regenable, ramread, ramenable, pcControl,
                imControl, aluop, illegal, halted, retired};

  function automatic logic [VW-1:0] ev(input logic [2:0] st, input logic [6:0] en,
                                       input logic [1:0] ao, input logic il, input logic ha);
    return {st, en, ao, il, ha, exp_ret};
  endfunction

  function automatic logic [IW-1:0] mk(input logic [5:0] op, input logic [4:0] a,
                                       input logic [4:0] b, input logic [15:0] im);
    return {op, a, b, im};
  endfunction

  // driver tasks: called at posedge+1, each covers exactly one clock cycle
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_cycle(input string tag, input logic [VW-1:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
    step();
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    mem_ready = 1'b0;
    zero      = 1'b0;
    exp_ret   = '0;
    expect_cycle("reset", ev(ST_FETCH, 7'd0, 2'd0, 1'b0, 1'b0));
    reset = 1'b0;
  endtask

  task automatic c_fetch(input logic [IW-1:0] ins, input logic mr);
    instruction = ins;
    mem_ready   = mr;
    expect_cycle("fetch", ev(ST_FETCH, mr ? (E_F | E_PE) : E_F, 2'd0, 1'b0, 1'b0));
  endtask

  task automatic c_decode(input logic il);
    instruction = $urandom;
    mem_ready   = 1'($urandom_range(0, 1));
    expect_cycle("decode", ev(ST_DECODE, 7'd0, 2'd0, il, 1'b0));
  endtask

  task automatic c_exec(input logic [6:0] en, input logic [1:0] ao, input logic z,
                        input logic ret);
    zero = z;
    expect_cycle("exec", ev(ST_EXEC, en, ao, 1'b0, 1'b0));
    if (ret) exp_ret = exp_ret + 4'd1;
  endtask

  task automatic c_mem(input logic [6:0] en, input logic mr, input logic ret);
    mem_ready = mr;
    expect_cycle("mem", ev(ST_MEM, en, 2'd0, 1'b0, 1'b0));
    if (ret) exp_ret = exp_ret + 4'd1;
  endtask

  task automatic c_wb();
    expect_cycle("wb", ev(ST_WB, E_RE, 2'd0, 1'b0, 1'b0));
    exp_ret = exp_ret + 4'd1;
  endtask

  task automatic c_halt();
    mem_ready   = 1'b1;
    instruction = $urandom;
    expect_cycle("halt", ev(ST_HALT, 7'd0, 2'd0, 1'b0, 1'b1));
  endtask

  task automatic alu_instr(input logic [5:0] op, input logic [6:0] en, input logic [1:0] ao);
    c_fetch(mk(op, 5'd1, 5'd2, 16'h00ff), 1'b1);
    c_decode(1'b0);
    c_exec(en, ao, 1'b0, 1'b0);
    c_wb();
  endtask

  task automatic jmp_instr();
    c_fetch(mk(6'd7, 5'd0, 5'd0, 16'h0040), 1'b1);
    c_decode(1'b0);
    c_exec(E_PC, 2'd0, 1'b0, 1'b1);
  endtask

  task automatic check_fields(input logic [5:0] eo, input logic [4:0] e1,
                              input logic [4:0] e2, input logic [15:0] ei);
    tests++;
    if ({opcode, op1, op2, imm} !== {eo, e1, e2, ei}) begin
      fails++;
      $display("FAIL fields: got %h want %h", {opcode, op1, op2, imm}, {eo, e1, e2, ei});
    end
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      mon_v = exp_q.pop_front();
      mon_t = tag_q.pop_front();
      tests++;
      if (act !== mon_v) begin
        fails++;
        $display("FAIL %s @%0t: got %h want %h (state,en7,aluop,ill,halt,ret)",
                 mon_t, $time, act, mon_v);
      end
    end
  end

  initial begin
    #100000;
    fails++;
    $display("FAIL watchdog: bench did not finish in time");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    reset       = 1'b1;
    instruction = '0;
    mem_ready   = 1'b0;
    zero        = 1'b0;
    exp_ret     = '0;
    step();
    do_reset();

    // ADD r3, r4 with full field decode
    c_fetch(mk(6'd0, 5'd3, 5'd4, 16'h1234), 1'b1);
    check_fields(6'd0, 5'd3, 5'd4, 16'h1234);
    c_decode(1'b0);
    c_exec(7'd0, 2'd0, 1'b0, 1'b0);
    c_wb();

    alu_instr(6'd1, 7'd0, 2'd1);
    alu_instr(6'd2, 7'd0, 2'd2);
    alu_instr(6'd3, E_IM, 2'd0);

    // LW: one stalled fetch, then three stalled MEM cycles
    c_fetch(mk(6'd4, 5'd5, 5'd6, 16'h0010), 1'b0);
    c_fetch(mk(6'd4, 5'd5, 5'd6, 16'h0010), 1'b1);
    c_decode(1'b0);
    c_exec(E_IM, 2'd0, 1'b0, 1'b0);
    repeat (3) c_mem(E_RR, 1'b0, 1'b0);
    c_mem(E_RR, 1'b1, 1'b0);
    c_wb();

    // SW with immediate memory completion
    c_fetch(mk(6'd5, 5'd7, 5'd8, 16'h0020), 1'b1);
    c_decode(1'b0);
    c_exec(E_IM, 2'd0, 1'b0, 1'b0);
    c_mem(E_WE, 1'b1, 1'b1);

    // BEQ taken then not taken
    c_fetch(mk(6'd6, 5'd1, 5'd1, 16'h0008), 1'b1);
    c_decode(1'b0);
    c_exec(E_PC, 2'd1, 1'b1, 1'b1);
    c_fetch(mk(6'd6, 5'd1, 5'd2, 16'h0008), 1'b1);
    c_decode(1'b0);
    c_exec(7'd0, 2'd1, 1'b0, 1'b1);

    jmp_instr();

    // illegal opcode 12: pulse in DECODE, back to FETCH, no retire
    c_fetch(mk(6'd12, 5'd1, 5'd2, 16'hffff), 1'b1);
    c_decode(1'b1);
    c_fetch(mk(6'd0, 5'd1, 5'd2, 16'h0000), 1'b0);

    // HALT is sticky
    c_fetch(mk(6'd63, 5'd0, 5'd0, 16'h0000), 1'b1);
    c_decode(1'b0);
    repeat (12) c_halt();
    do_reset();

    // 16 jumps wrap the 4-bit retired counter back to 0
    repeat (16) jmp_instr();
    c_fetch(mk(6'd0, 5'd0, 5'd0, 16'h0000), 1'b0);

    // reset in the middle of a stalled SW
    do_reset();
    alu_instr(6'd0, 7'd0, 2'd0);
    c_fetch(mk(6'd5, 5'd9, 5'd10, 16'h0030), 1'b1);
    c_decode(1'b0);
    c_exec(E_IM, 2'd0, 1'b0, 1'b0);
    c_mem(E_WE, 1'b0, 1'b0);
    do_reset();
    c_fetch(mk(6'd7, 5'd0, 5'd0, 16'h0000), 1'b0);
    jmp_instr();
    c_fetch(mk(6'd0, 5'd0, 5'd0, 16'h0000), 1'b0);

    step();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
